serial_subtractor_ctrl: RTL
===========================

# serial_subtractor_ctrl

Bit-serial subtraction controller. It computes `a - b - bin` for WIDTH-bit operands by sequencing one 1-bit full-subtractor cell LSB-first, one bit per clock. A start/ready/done handshake sits on the front, and the borrow is registered between bits. It is the area-minimal subtract unit for control paths where a WIDTH-cycle latency is acceptable.

## Interface
- `WIDTH`, default 8: operand and result width; legal range 2..32.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a new subtraction; accepted only when `ready`=1.
- `a` input WIDTH: minuend; sampled on the accepting edge only.
- `b` input WIDTH: subtrahend; sampled on the accepting edge only.
- `bin` input 1: initial borrow-in; sampled on the accepting edge only.
- `ready` output 1: controller idle and able to accept `start`.
- `busy` output 1: bit-serial operation in progress.
- `done` output 1: one-cycle pulse; `diff`, `bout` and `ovf` are valid and newly updated.
- `diff` output WIDTH: result `(a - b - bin) mod 2^WIDTH`.
- `bout` output 1: final borrow-out; 1 exactly when `a < b + bin` (unsigned).
- `ovf` output 1: two's-complement overflow of the signed subtraction.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - `ready`=1, `busy`=0.
  - On an edge with `start`=1: latch `a`, `b` and `bin` into shift/borrow registers, clear the bit counter, go to SHIFT.
- SHIFT:
  - `busy`=1, `ready`=0.
  - Each edge: the cell takes `a_sh[0]`, `b_sh[0]` and `borrow_r`.
  - Its diff bit shifts into the MSB of `diff_sh`; `a_sh` and `b_sh` shift right; `borrow_r` takes the cell's bout; the counter increments.
  - On the edge where the counter reaches WIDTH-1 (the WIDTH-th SHIFT edge): load output registers `diff`, `bout` and `ovf`, go to DONE.
- DONE:
  - `done`=1, `busy`=0, `ready`=0.
  - Next edge returns to IDLE unconditionally.
- Overflow rule: `ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using latched operands. `bin` does not enter this formula.
- `start` while not IDLE is ignored entirely; no queuing, and latched operands are unaffected.
- Operand inputs may change freely after the accepting edge.
- Output registers `diff`, `bout` and `ovf` hold their last values until the next DONE load.

## Timing
- Reset values:
  - state=IDLE, `ready`=1, `busy`=0, `done`=0.
  - `diff`=0, `bout`=0, `ovf`=0.
  - Internal shift, borrow and counter registers cleared.
- Latency:
  - Start accepted on edge 0.
  - `done` is high in the cycle following edge WIDTH; results are visible in that same cycle.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is the edge after DONE, where `ready`=1.
- Reset asserted mid-SHIFT or in DONE:
  - Aborts the operation; `done` never pulses for it.
  - All outputs take reset values on that edge.
- Reset and `start` on the same edge: reset wins; nothing is accepted.
- `ready`, `busy` and `done` are decoded from registered state only: glitch-free and mutually exclusive.

## Structure
- Shared package `serial_sub_pkg` holds:
  - state encoding constants IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
  - the counter-width function `$clog2(WIDTH)`.
- One sub-module is instantiated: the team's existing combinational `full_subtractor` cell (`a`, `b`, `bin` -> `diff`, `bout`).
  - `full_subtractor` is used unmodified.
  - All sequencing, shift registers and output registers live in `serial_subtractor_ctrl`.

## Test plan
- **Basic subtraction** (WIDTH=8): `a`=0x5A, `b`=0x3C, `bin`=0, `start` pulse -> `done` exactly 8 cycles after accept with `diff`=0x1E, `bout`=0, `ovf`=0; `busy` high for 8 cycles.
- **Underflow and signed overflow:**
  - 0x00 - 0x01 -> `diff`=0xFF, `bout`=1, `ovf`=0.
  - 0x80 - 0x01 -> `diff`=0x7F, `bout`=0, `ovf`=1.
  - 0x7F - 0xFF -> `diff`=0x80, `bout`=1, `ovf`=1.
- **Borrow-in:**
  - 0x10 - 0x0F with `bin`=1 -> `diff`=0x00, `bout`=0.
  - 0x00 - 0x00 with `bin`=1 -> `diff`=0xFF, `bout`=1.
- **Protocol:**
  - `start` held high continuously -> accepts only when `ready`=1, one result per 10 cycles.
  - `start` with different operands during SHIFT -> ignored; the result matches the original operands.
- **Reset mid-operation:** assert `rst` on the 3rd SHIFT edge -> next cycle `ready`=1, `diff`=0, `bout`=0, `ovf`=0, and `done` never pulses. The following operation 0x05 - 0x03 gives `diff`=0x02.
- **Exhaustive check** (WIDTH=4): all 512 combinations of `a`, `b` and `bin` -> `diff`, `bout` and `ovf` match the arithmetic model; every operation takes exactly 6 cycles accept-to-accept.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Width of a counter that must hold values 0..width-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: diff = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow whenever at least two of (~a, b, bin) are set.
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin: one full-subtractor cell stepped LSB-first, one bit
// per clock, behind a start/ready/done handshake.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_diff_sh;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_cell_diff;
  logic             w_cell_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_diff_final;

  full_subtractor u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_borrow),
    .diff (w_cell_diff),
    .bout (w_cell_bout)
  );

  assign w_last       = (r_cnt == LAST);
  // The bit produced on the final step is the MSB of the result.
  assign w_diff_final = {w_cell_diff, r_diff_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_diff_sh <= '0;
      r_borrow  <= 1'b0;
      r_cnt     <= '0;
      r_a_msb   <= 1'b0;
      r_b_msb   <= 1'b0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_borrow  <= bin;
            r_a_msb   <= a[WIDTH-1];
            r_b_msb   <= b[WIDTH-1];
            r_diff_sh <= '0;
            r_cnt     <= '0;
          end
        end
        SHIFT: begin
          r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_diff_sh <= w_diff_final[WIDTH-1:1];
          r_borrow  <= w_cell_bout;
          r_cnt     <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_diff_final;
            r_bout <= w_cell_bout;
            // Signed overflow: operand signs differ and result sign differs from a.
            r_ovf  <= (r_a_msb != r_b_msb) && (w_cell_diff != r_a_msb);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule
